// File: rtl/instruction_prefetch.sv
// instruction_prefetch: fetch/prefetch stage in front of decode.
// Drives the instruction byte addresses (IA0/IA1) and captures the memory
// word into a small FIFO. The FIFO is presented to decode through a
// valid/ready handshake. A branch flushes the FIFO and restarts fetch at
// the even-aligned target address.
// Optional feature macro: PREFETCH_FAULT_EN. When it is defined, an
// out-of-range fetch is tagged and fetching halts until the next branch or
// reset. When it is undefined, the fault output is tied low and fetch never
// halts.
module instruction_prefetch #(
  parameter int         DEPTH    = 4,
  parameter logic [9:0] RESET_PC = 10'd0,
  parameter int         MEM_SIZE = 84
) (
  input  logic        clock,
  input  logic        reset,
  output logic [9:0]  IA0,
  output logic [9:0]  IA1,
  input  logic [15:0] PreInstruction,
  input  logic        branch,
  input  logic [9:0]  branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] Instruction,
  output logic [9:0]  instr_pc,
  output logic        instr_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [9:0]    fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [15:0] word_mem  [DEPTH];
  logic [9:0]  pc_mem    [DEPTH];
  logic        fault_mem [DEPTH];

  logic        pop;
  logic        push;
  logic        fetch_fault;
  logic [10:0] pc_plus1;

`ifdef PREFETCH_FAULT_EN
  logic halted;
`endif

  assign IA0 = fetch_pc;
  assign IA1 = fetch_pc + 10'd1;

  assign instr_valid = (count != '0);
  assign Instruction = word_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];

`ifdef PREFETCH_FAULT_EN
  assign instr_fault = fault_mem[rd_ptr];
`else
  logic unused_head_fault;
  assign unused_head_fault = fault_mem[rd_ptr];
  assign instr_fault = 1'b0;
`endif

  // Handshake and fetch decisions; a branch in the same cycle cancels both.
  always_comb begin
    pop         = 1'b0;
    push        = 1'b0;
    pc_plus1    = {1'b0, fetch_pc} + 11'd1;
    fetch_fault = (pc_plus1 >= 11'(MEM_SIZE));
    pop         = instr_valid && instr_ready && !branch;
`ifdef PREFETCH_FAULT_EN
    push        = !branch && !halted && ((count < CW'(DEPTH)) || pop);
`else
    push        = !branch && ((count < CW'(DEPTH)) || pop);
`endif
  end

  // Fetch address, FIFO pointers, occupancy and the halt flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
`ifdef PREFETCH_FAULT_EN
      halted   <= 1'b0;
`endif
    end else if (branch) begin
      fetch_pc <= {branch_target[9:1], 1'b0};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
`ifdef PREFETCH_FAULT_EN
      halted   <= 1'b0;
`endif
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 10'd2;
        wr_ptr   <= wr_ptr + 1'b1;
`ifdef PREFETCH_FAULT_EN
        halted   <= fetch_fault;
`endif
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: captures the fetched word, its address and the range tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i]  <= '0;
        pc_mem[i]    <= '0;
        fault_mem[i] <= 1'b0;
      end
    end else if (push) begin
      word_mem[wr_ptr]  <= PreInstruction;
      pc_mem[wr_ptr]    <= fetch_pc;
      fault_mem[wr_ptr] <= fetch_fault;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch.sv
// tb_instruction_prefetch: directed bench for instruction_prefetch with a
// combinational byte memory of 84 bytes (out-of-range reads return 16'hE800).
// Expected values in the PREFETCH_FAULT_EN cases follow the same macro.
module tb_instruction_prefetch;

  logic        clock;
  logic        reset;
  logic [9:0]  IA0;
  logic [9:0]  IA1;
  logic [15:0] PreInstruction;
  logic        branch;
  logic [9:0]  branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] Instruction;
  logic [9:0]  instr_pc;
  logic        instr_fault;

  int checkCount;
  int errorCount;

  instruction_prefetch #(
    .DEPTH(4),
    .RESET_PC(10'd0),
    .MEM_SIZE(84)
  ) dut (
    .clock(clock),
    .reset(reset),
    .IA0(IA0),
    .IA1(IA1),
    .PreInstruction(PreInstruction),
    .branch(branch),
    .branch_target(branch_target),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .Instruction(Instruction),
    .instr_pc(instr_pc),
    .instr_fault(instr_fault)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory byte contents: byte at address a is a*7+3 (low 8 bits).
  function automatic logic [7:0] ramByte(input logic [9:0] addr);
    int v;
    v = int'(addr) * 7 + 3;
    return v[7:0];
  endfunction

  // Word the memory returns for an even fetch address.
  function automatic logic [15:0] memWord(input logic [9:0] pc);
    if (pc < 10'd84)
      return {ramByte(pc + 10'd1), ramByte(pc)};
    else
      return 16'hE800;
  endfunction

  // Memory read port model.
  always_comb begin
    PreInstruction = memWord(IA0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs, let one rising edge pass, then settle for sampling.
  task automatic applyStimulus(input logic rst, input logic br,
                               input logic [9:0] tgt, input logic rdy);
    reset         = rst;
    branch        = br;
    branch_target = tgt;
    instr_ready   = rdy;
    @(posedge clock);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    branch = 1'b0;
    branch_target = 10'd0;
    instr_ready = 1'b1;

    // Reset state
    applyStimulus(1'b1, 1'b0, 10'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 10'd0, 1'b1);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_ia0",   32'(IA0), 32'd0);
    checkOutput("rst_ia1",   32'(IA1), 32'd1);
    checkOutput("rst_instr", 32'(Instruction), 32'h0000);
    checkOutput("rst_pc",    32'(instr_pc), 32'd0);
    checkOutput("rst_fault", 32'(instr_fault), 32'd0);

    // Streaming with decode always ready: one instruction per cycle
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 1'b1);
      checkOutput("stream_valid", 32'(instr_valid), 32'd1);
      checkOutput("stream_pc",    32'(instr_pc), 32'(2 * k));
      checkOutput("stream_word",  32'(Instruction), 32'(memWord(10'(2 * k))));
      checkOutput("stream_ia0",   32'(IA0), 32'(2 * k + 2));
    end

    // Decode stalled for 6 cycles after reset: FIFO fills, fetch stops at 8
    applyStimulus(1'b1, 1'b0, 10'd0, 1'b0);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 10'd0, 1'b0);
    checkOutput("stall_ia0",   32'(IA0), 32'd8);
    checkOutput("stall_valid", 32'(instr_valid), 32'd1);
    checkOutput("stall_pc",    32'(instr_pc), 32'd0);

    // Release: pop and push together at full, no gap
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 1'b1);
      checkOutput("drain_valid", 32'(instr_valid), 32'd1);
      checkOutput("drain_pc",    32'(instr_pc), 32'(2 * k));
      checkOutput("drain_ia0",   32'(IA0), 32'(8 + 2 * k));
    end

    // Full and not popping: fetch address holds
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0);
    checkOutput("full_hold_ia0", 32'(IA0), 32'd16);
    checkOutput("full_hold_pc",  32'(instr_pc), 32'd8);

    // Branch from full FIFO to an odd target
    applyStimulus(1'b0, 1'b1, 10'h15, 1'b0);
    checkOutput("br_valid", 32'(instr_valid), 32'd0);
    checkOutput("br_ia0",   32'(IA0), 32'h14);
    checkOutput("br_ia1",   32'(IA1), 32'h15);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b1);
    checkOutput("br_tgt_valid", 32'(instr_valid), 32'd1);
    checkOutput("br_tgt_pc",    32'(instr_pc), 32'h14);
    checkOutput("br_tgt_word",  32'(Instruction), 32'(memWord(10'h14)));

    // Fetching across the end of memory
    applyStimulus(1'b0, 1'b1, 10'd82, 1'b1);
    checkOutput("edge_br_valid", 32'(instr_valid), 32'd0);
    checkOutput("edge_br_ia0",   32'(IA0), 32'd82);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b1);
    checkOutput("pc82_pc",    32'(instr_pc), 32'd82);
    checkOutput("pc82_fault", 32'(instr_fault), 32'd0);
    checkOutput("pc82_word",  32'(Instruction), 32'(memWord(10'd82)));
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b1);
    checkOutput("pc84_pc",   32'(instr_pc), 32'd84);
    checkOutput("pc84_word", 32'(Instruction), 32'hE800);
    checkOutput("pc84_ia0",  32'(IA0), 32'd86);
`ifdef PREFETCH_FAULT_EN
    checkOutput("pc84_fault", 32'(instr_fault), 32'd1);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b1);
    checkOutput("halt_valid", 32'(instr_valid), 32'd0);
    checkOutput("halt_ia0",   32'(IA0), 32'd86);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b1);
    checkOutput("halt_ia0_held", 32'(IA0), 32'd86);
`else
    checkOutput("pc84_fault", 32'(instr_fault), 32'd0);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b1);
    checkOutput("pc86_valid", 32'(instr_valid), 32'd1);
    checkOutput("pc86_pc",    32'(instr_pc), 32'd86);
    checkOutput("pc86_word",  32'(Instruction), 32'hE800);
    checkOutput("pc86_ia0",   32'(IA0), 32'd88);
`endif

    // Branch restarts fetch (also clears any halt)
    applyStimulus(1'b0, 1'b1, 10'd4, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b1);
    checkOutput("recover_valid", 32'(instr_valid), 32'd1);
    checkOutput("recover_pc",    32'(instr_pc), 32'd4);
    checkOutput("recover_fault", 32'(instr_fault), 32'd0);

    // Three entries queued, then reset together with a branch
    applyStimulus(1'b0, 1'b1, 10'h10, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 10'd0, 1'b0);
    checkOutput("q3_pc",  32'(instr_pc), 32'h10);
    checkOutput("q3_ia0", 32'(IA0), 32'h16);
    applyStimulus(1'b1, 1'b1, 10'h30, 1'b1);
    checkOutput("midrst_valid", 32'(instr_valid), 32'd0);
    checkOutput("midrst_ia0",   32'(IA0), 32'd0);
    checkOutput("midrst_instr", 32'(Instruction), 32'h0000);
    checkOutput("midrst_pc",    32'(instr_pc), 32'd0);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b1);
    checkOutput("restart_valid", 32'(instr_valid), 32'd1);
    checkOutput("restart_pc0",   32'(instr_pc), 32'd0);
    checkOutput("restart_word",  32'(Instruction), 32'h0A03);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b1);
    checkOutput("restart_pc2",   32'(instr_pc), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
